sram_like_port_arbiter: RTL and testbench
=========================================

Name: sram_like_port_arbiter

Overview:
- Shares one unified sram-like memory port between the CPU's instruction-fetch requester and its data requester.
- Sits between the pipeline's inst/data sram-like masters and the single memory/bridge slave.
- Allows exactly one outstanding transaction at a time.
- Selects a requester, forwards its request, tracks the owner and routes the returned data back to that owner.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, read/write data width of all ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- inst_req  in  1  instruction-side request valid.
- inst_wr  in  1  instruction-side write flag; normally 0.
- inst_size  in  2  transfer size: 0=byte, 1=half, 2=word.
- inst_addr  in  ADDR_W  instruction-side address.
- inst_wdata  in  DATA_W  instruction-side write data.
- inst_addr_ok  out  1  instruction request accepted.
- inst_data_ok  out  1  instruction data returned.
- inst_rdata  out  DATA_W  instruction read data.
- data_req  in  1  data-side request valid.
- data_wr  in  1  data-side write flag.
- data_size  in  2  data-side transfer size.
- data_addr  in  ADDR_W  data-side address.
- data_wdata  in  DATA_W  data-side write data.
- data_addr_ok  out  1  data request accepted.
- data_data_ok  out  1  data read returned / write completed.
- data_rdata  out  DATA_W  data read data.
- m_req  out  1  request to memory.
- m_wr  out  1  forwarded write flag.
- m_size  out  2  forwarded size.
- m_addr  out  ADDR_W  forwarded address.
- m_wdata  out  DATA_W  forwarded write data.
- m_addr_ok  in  1  memory accepted the request.
- m_data_ok  in  1  memory response valid.
- m_rdata  in  DATA_W  memory read data.
- proto_err  out  1  sticky flag: m_data_ok arrived with no outstanding transaction.

Behaviour:
- Interface is decided: one clock, clk; reset is resetn, asynchronous and active-low.
- State machine, 2 states: IDLE, WAIT.
- Owner register, 1 bit: INST=0, DATA=1.
- Reset values: state=IDLE, owner=INST, last_grant=INST, proto_err=0.
- While resetn=0, every output is 0: m_req, both addr_ok, both data_ok, all m_* fields and both rdata.
- IDLE, grant selection (combinational, fixed priority):
  - data_req=1 → grant DATA.
  - else inst_req=1 → grant INST.
  - else no grant and m_req=0.
- IDLE with a grant:
  - m_req=1; m_wr, m_size, m_addr and m_wdata are muxed from the granted side.
  - granted side's addr_ok = m_addr_ok; the other side's addr_ok=0.
- Handshake m_req & m_addr_ok: owner ← grant, last_grant ← grant, state → WAIT at the next edge.
- Without a handshake, state stays IDLE and the grant is re-evaluated every cycle.
  - A requester must hold req and its fields stable until addr_ok.
  - A losing requester waits.
- WAIT:
  - m_req=0 and both addr_ok=0; new requests are blocked.
  - Owner's data_ok = m_data_ok; the non-owner's data_ok=0.
  - inst_rdata and data_rdata are both driven from m_rdata; only the owner's data_ok qualifies it.
  - On m_data_ok → IDLE at the next edge.
  - Each transaction costs at least one bubble cycle: no new request in the cycle of m_data_ok.
- m_data_ok while IDLE: proto_err ← 1, sticky until reset; neither data_ok asserts; state unchanged.
- m_addr_ok while IDLE and m_req=0: ignored.
- Reset mid-transaction (in WAIT): immediate return to IDLE; any later m_data_ok sets proto_err.
- Simultaneous requests: DATA wins by default; INST proceeds in the next IDLE window.
  - Starvation of INST under a continuous data stream is accepted without the optional feature.
- Latency: addr_ok is combinational in the cycle memory accepts; data_ok is combinational from m_data_ok.

Optional Feature:
- Macro: SRAM_ARB_ROUND_ROBIN_EN.
- Defined: when inst_req and data_req are both 1 in IDLE, grant the side opposite to last_grant. A single requester is granted regardless.
- Undefined: fixed DATA-over-INST priority; last_grant is unused and may be removed.

Decomposition:
- Shared package holds:
  - owner encodings OWNER_INST=0, OWNER_DATA=1;
  - state encodings ST_IDLE=0, ST_WAIT=1;
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
- Natural sub-module: sram_arb_grant. Purely combinational; takes both reqs plus last_grant, returns grant_valid and grant_id. Isolates the priority policy and the optional feature.
- The FSM, owner register and muxes stay in the top module.

Test Plan:
- Single INST read:
  - Stimulus: inst_req=1, addr=0xBFC00000; m_addr_ok=1 in the same cycle; m_data_ok=1 two cycles later with m_rdata=0x3C1D0000.
  - Required: inst_addr_ok pulses 1 cycle; inst_data_ok pulses with inst_rdata=0x3C1D0000; data_data_ok stays 0.
- Simultaneous requests, fixed priority:
  - Stimulus: inst_req=data_req=1, data_addr=0x1000, data_wr=1, wdata=0xDEADBEEF.
  - Required: m_addr=0x1000, m_wdata=0xDEADBEEF; data_addr_ok=1 and inst_addr_ok=0. INST is granted in the cycle after data_data_ok.
- Backpressure:
  - Stimulus: data_req=1 held; m_addr_ok=0 for 3 cycles, then 1.
  - Required: m_req=1 and the fields are stable all 4 cycles; a single data_addr_ok pulse; state enters WAIT.
- Round-robin (macro defined):
  - Stimulus: both reqs held continuously across 4 transactions.
  - Required: grant order DATA, INST, DATA, INST.
- Protocol error:
  - Stimulus: m_data_ok=1 while IDLE.
  - Required: proto_err=1 from the next cycle and remains 1; no data_ok asserted. resetn=0 clears it.
- Reset in WAIT:
  - Stimulus: assert resetn=0 mid-transaction; release; then apply m_data_ok.
  - Required: outputs 0 during reset; state IDLE after release; proto_err=1; no data_ok delivered.

Source files
------------

// File: rtl/sram_like_port_arbiter_pkg.sv
// Shared encodings for the sram-like port arbiter: owner ids, FSM states, transfer sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_like_port_arbiter_pkg;

   // Which requester owns the single outstanding transaction
   localparam logic OWNER_INST = 1'b0;
   localparam logic OWNER_DATA = 1'b1;

   // Arbiter FSM: IDLE accepts a new request, WAIT blocks until the response returns
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // sram-like transfer size field
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_arb_grant.sv
// Grant policy: picks INST or DATA from the two request lines (fixed DATA priority, or
// alternating on a tie when SRAM_ARB_ROUND_ROBIN_EN is defined). Latency: combinational.
// Backpressure: none; the caller decides whether the grant is used this cycle.
module sram_arb_grant
   import sram_like_port_arbiter_pkg::*;
(
   input  logic i_inst_req,
   input  logic i_data_req,
`ifdef SRAM_ARB_ROUND_ROBIN_EN
   input  logic i_last_grant,
`endif
   output logic o_grant_vld,
   output logic o_grant_id
);

   // Select a requester; a lone requester always wins, ties go to DATA or alternate
   always_comb begin
      o_grant_vld = i_inst_req | i_data_req;
      o_grant_id  = i_data_req ? OWNER_DATA : OWNER_INST;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      if (i_inst_req && i_data_req) begin
         o_grant_id = ~i_last_grant;
      end
`endif
   end

endmodule

// File: rtl/sram_like_port_arbiter.sv
// Shares one sram-like memory port between inst and data masters, one outstanding
// transaction at a time. Latency: addr_ok/data_ok combinational from m_addr_ok/m_data_ok.
// Backpressure: loser and blocked requests hold until addr_ok; optional SRAM_ARB_ROUND_ROBIN_EN.
module sram_like_port_arbiter
   import sram_like_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              inst_req,
   input  logic              inst_wr,
   input  logic [1:0]        inst_size,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic [DATA_W-1:0] inst_wdata,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,
   output logic              m_req,
   output logic              m_wr,
   output logic [1:0]        m_size,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_addr_ok,
   input  logic              m_data_ok,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              proto_err
);

   state_t r_state;
   logic   r_owner;
   logic   r_proto_err;
   logic   w_grant_vld;
   logic   w_grant_id;
   logic   w_idle;
   logic   w_req;
   logic   w_hs;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic   r_last_grant;
`endif

   sram_arb_grant u_grant (
      .i_inst_req   (inst_req),
      .i_data_req   (data_req),
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      .i_last_grant (r_last_grant),
`endif
      .o_grant_vld  (w_grant_vld),
      .o_grant_id   (w_grant_id)
   );

   assign w_idle = (r_state == ST_IDLE);
   // resetn gates the request so every output is quiet while reset is held
   assign w_req  = resetn & w_idle & w_grant_vld;
   assign w_hs   = w_req & m_addr_ok;

   // Forward the granted side's request fields; outputs are forced low while reset is held
   always_comb begin
      m_req        = w_req;
      m_wr         = 1'b0;
      m_size       = 2'd0;
      m_addr       = '0;
      m_wdata      = '0;
      inst_addr_ok = w_hs & (w_grant_id == OWNER_INST);
      data_addr_ok = w_hs & (w_grant_id == OWNER_DATA);
      inst_data_ok = resetn & ~w_idle & m_data_ok & (r_owner == OWNER_INST);
      data_data_ok = resetn & ~w_idle & m_data_ok & (r_owner == OWNER_DATA);
      inst_rdata   = resetn ? m_rdata : '0;
      data_rdata   = resetn ? m_rdata : '0;
      proto_err    = r_proto_err;
      if (w_req) begin
         if (w_grant_id == OWNER_DATA) begin
            m_wr    = data_wr;
            m_size  = data_size;
            m_addr  = data_addr;
            m_wdata = data_wdata;
         end else begin
            m_wr    = inst_wr;
            m_size  = inst_size;
            m_addr  = inst_addr;
            m_wdata = inst_wdata;
         end
      end
   end

   // One-outstanding FSM: latch the owner on accept, release on response, flag stray responses
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= ST_IDLE;
         r_owner     <= OWNER_INST;
         r_proto_err <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         r_last_grant <= OWNER_INST;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (m_data_ok) begin
                  r_proto_err <= 1'b1;
               end
               if (w_hs) begin
                  r_owner <= w_grant_id;
                  r_state <= ST_WAIT;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                  r_last_grant <= w_grant_id;
`endif
               end
            end
            ST_WAIT: begin
               if (m_data_ok) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_like_port_arbiter.sv
// Self-checking bench for the sram-like port arbiter: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference model.
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
module tb_sram_like_port_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        m_req, m_wr;
   logic [1:0]  m_size;
   logic [31:0] m_addr, m_wdata;
   logic        m_addr_ok, m_data_ok;
   logic [31:0] m_rdata;
   logic        proto_err;

   int n_vec = 0;
   int n_err = 0;

   // reference model: is a transaction outstanding, who owns it, who won last, sticky error
   bit busy, owner, last_g, perr;
   bit acc_inst, acc_data;

   always #5 clk = ~clk;

   sram_like_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
      .proto_err(proto_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Who should win: a single requester wins; on a tie DATA wins, or alternation when enabled
   function automatic bit pick(input bit ir, input bit dr, input bit lg);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      if (ir && dr) return !lg;
`endif
      return dr ? 1'b1 : 1'b0;
   endfunction

   // One clock: compare outputs against the model, then advance the model at the rising edge
   task automatic step();
      bit e_req, g, e_iao, e_dao;
      #1;
      if (!resetn) begin
         busy = 0; owner = 0; last_g = 0; perr = 0;
      end
      e_req = resetn && !busy && (inst_req || data_req);
      g     = pick(inst_req, data_req, last_g);
      e_iao = e_req && !g && m_addr_ok;
      e_dao = e_req &&  g && m_addr_ok;
      check("m_req", {31'b0, m_req}, {31'b0, e_req});
      if (e_req) begin
         check("m_wr",    {31'b0, m_wr},   {31'b0, g ? data_wr : inst_wr});
         check("m_size",  {30'b0, m_size}, {30'b0, g ? data_size : inst_size});
         check("m_addr",  m_addr,  g ? data_addr : inst_addr);
         check("m_wdata", m_wdata, g ? data_wdata : inst_wdata);
      end
      if (!resetn) begin
         check("rst_m_fields", {m_addr[15:0], m_wdata[12:0], m_wr, m_size}, 32'h0);
      end
      check("inst_addr_ok", {31'b0, inst_addr_ok}, {31'b0, e_iao});
      check("data_addr_ok", {31'b0, data_addr_ok}, {31'b0, e_dao});
      check("inst_data_ok", {31'b0, inst_data_ok}, {31'b0, resetn && busy && !owner && m_data_ok});
      check("data_data_ok", {31'b0, data_data_ok}, {31'b0, resetn && busy && owner && m_data_ok});
      check("inst_rdata", inst_rdata, resetn ? m_rdata : 32'h0);
      check("data_rdata", data_rdata, resetn ? m_rdata : 32'h0);
      check("proto_err", {31'b0, proto_err}, {31'b0, perr});
      acc_inst = e_iao;
      acc_data = e_dao;
      @(posedge clk);
      if (resetn) begin
         if (!busy && m_data_ok) perr = 1;
         if (e_req && m_addr_ok) begin
            busy = 1; owner = g; last_g = g;
         end else if (busy && m_data_ok) begin
            busy = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
      data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
      m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
   endtask

   task automatic do_reset();
      resetn = 0;
      idle_inputs();
      step();
      step();
      resetn = 1;
      step();
   endtask

   initial begin
      resetn = 0;
      idle_inputs();
      @(negedge clk);
      do_reset();

      // single INST read
      inst_req = 1; inst_addr = 32'hBFC0_0000; m_addr_ok = 1;
      step();
      check("inst_accept", {31'b0, acc_inst}, 32'd1);
      inst_req = 0; m_addr_ok = 0;
      step();
      m_data_ok = 1; m_rdata = 32'h3C1D_0000;
      step();
      m_data_ok = 0;
      step();

      // simultaneous requests: DATA first, INST right after the response
      inst_req = 1; inst_addr = 32'hBFC0_0004;
      data_req = 1; data_wr = 1; data_addr = 32'h0000_1000; data_wdata = 32'hDEAD_BEEF;
      m_addr_ok = 1;
      step();
      check("tie_data_first", {31'b0, acc_data}, 32'd1);
      data_req = 0; data_wr = 0; m_addr_ok = 0;
      step();
      m_data_ok = 1; m_rdata = 32'h1234_5678;
      step();
      m_data_ok = 0; m_addr_ok = 1;
      step();
      check("inst_after_data", {31'b0, acc_inst}, 32'd1);
      inst_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h0BAD_F00D;
      step();
      m_data_ok = 0;
      step();

      // backpressure: 3 refused cycles then accepted
      data_req = 1; data_addr = 32'h0000_2000; data_wdata = 32'hCAFE_0001; data_size = 2'd1;
      for (int i = 0; i < 3; i++) step();
      m_addr_ok = 1;
      step();
      data_req = 0; m_addr_ok = 0;
      step();
      m_data_ok = 1;
      step();
      m_data_ok = 0;

      // both requesters held across 4 transactions
      inst_req = 1; data_req = 1;
      for (int i = 0; i < 4; i++) begin
         inst_addr = 32'h100 + i; data_addr = 32'h200 + i;
         m_addr_ok = 1; m_data_ok = 0;
         step();
         m_addr_ok = 0; m_data_ok = 1; m_rdata = $urandom;
         step();
      end
      idle_inputs();
      step();

      // stray response while idle
      m_data_ok = 1; m_rdata = 32'h5555_AAAA;
      step();
      m_data_ok = 0;
      step();
      check("proto_err_sticky", {31'b0, proto_err}, 32'd1);
      step();
      do_reset();

      // reset in the middle of a transaction
      data_req = 1; data_addr = 32'h3000; m_addr_ok = 1;
      step();
      data_req = 0; m_addr_ok = 0;
      step();
      resetn = 0;
      step();
      resetn = 1;
      step();
      m_data_ok = 1; m_rdata = 32'h7777_7777;
      step();
      m_data_ok = 0;
      step();
      check("proto_err_after_rst", {31'b0, proto_err}, 32'd1);
      do_reset();

      // random traffic from well-behaved masters and memory
      for (int i = 0; i < 400; i++) begin
         if (!inst_req && ($urandom_range(0, 1) == 1)) begin
            inst_req = 1; inst_wr = ($urandom_range(0, 7) == 0);
            inst_size = 2'($urandom_range(0, 2)); inst_addr = $urandom; inst_wdata = $urandom;
         end
         if (!data_req && ($urandom_range(0, 1) == 1)) begin
            data_req = 1; data_wr = 1'($urandom_range(0, 1));
            data_size = 2'($urandom_range(0, 2)); data_addr = $urandom; data_wdata = $urandom;
         end
         m_addr_ok = 1'($urandom_range(0, 1));
         m_data_ok = busy ? ($urandom_range(0, 2) == 0) : 1'b0;
         m_rdata   = $urandom;
         step();
         if (acc_inst) inst_req = 0;
         if (acc_data) data_req = 0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
